// File: rtl/irig_pulse_classifier.sv
// IRIG-B receive front end: synchronise, deglitch and classify each high pulse
// as ZERO / ONE / MARK / ERROR, with loss-of-signal detection.
module irig_pulse_classifier #(
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned INVERT      = 0,
  parameter int unsigned ZERO_MIN    = 19000,
  parameter int unsigned ONE_MIN     = 49000,
  parameter int unsigned MARK_MIN    = 79000,
  parameter int unsigned MARK_MAX    = 89000,
  parameter int unsigned LOS_CYCLES  = 120000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irigb,
  output logic             sym_valid,
  output logic [1:0]       sym_code,
  output logic [CNT_W-1:0] sym_width,
  output logic             los,
  output logic [7:0]       err_cnt
);

  localparam logic             INV_B  = (INVERT != 0);
  localparam logic [3:0]       FL_M1  = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] ZERO_V = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] MARK_V = CNT_W'(MARK_MIN);
  localparam logic [CNT_W-1:0] MMAX_V = CNT_W'(MARK_MAX);
  localparam logic [CNT_W-1:0] LOS_V  = CNT_W'(LOS_CYCLES);

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_MARK = 2'b10;
  localparam logic [1:0] CODE_ERR  = 2'b11;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   s;
  logic                   vld;
  logic                   f, f_d;
  logic [3:0]             fcnt;
  logic                   armed;
  logic                   rise, rise_ok, fall;
  logic [CNT_W-1:0]       w;
  logic [CNT_W-1:0]       p;
  logic                   los_q, los_n;
  logic                   emit;
  logic [1:0]             code_c;

  // vld_q marks when the sync chain holds real samples rather than reset zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irigb};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s   = sync_q[SYNC_STAGES-1] ^ INV_B;
  assign vld = vld_q[SYNC_STAGES-1];

  // Rises are honoured only once the line has been seen low after reset,
  // so a pulse already in progress at reset release is never measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f     <= 1'b0;
      f_d   <= 1'b0;
      fcnt  <= '0;
      armed <= 1'b0;
    end else begin
      f_d   <= f;
      armed <= armed | (vld & ~s);
      if (s != f) begin
        if (fcnt == FL_M1) begin
          f    <= s;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 4'd1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign rise    = f & ~f_d;
  assign fall    = ~f & f_d;
  assign rise_ok = rise & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w <= '0;
      p <= '0;
    end else begin
      if (rise)
        w <= CNT_W'(1);
      else if (f && (w != '1))
        w <= w + CNT_W'(1);

      if (rise)
        p <= '0;
      else if (p != LOS_V)
        p <= p + CNT_W'(1);
    end
  end

  always_comb begin
    if (w < ZERO_V)       code_c = CODE_ERR;
    else if (w < ONE_V)   code_c = CODE_ZERO;
    else if (w < MARK_V)  code_c = CODE_ONE;
    else if (w <= MMAX_V) code_c = CODE_MARK;
    else                  code_c = CODE_ERR;
  end

  always_comb begin
    state_n = state;
    los_n   = los_q;
    emit    = 1'b0;
    if (rise_ok) begin
      state_n = HIGH;
      los_n   = 1'b0;
    end else if (p == LOS_V) begin
      state_n = IDLE;
      los_n   = 1'b1;
    end else begin
      case (state)
        HIGH: if (fall) begin
          state_n = LOW;
          emit    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      los_q     <= 1'b0;
      sym_valid <= 1'b0;
      sym_code  <= '0;
      sym_width <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      los_q     <= los_n;
      sym_valid <= emit;
      if (emit) begin
        sym_code  <= code_c;
        sym_width <= w;
        if ((code_c == CODE_ERR) && (err_cnt != 8'hFF))
          err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // los drops in the same cycle the returning signal's rise is accepted
  assign los = los_q & ~rise_ok;

endmodule

// File: tb/tb_irig_pulse_classifier.sv
// Randomised bench for irig_pulse_classifier with time-scaled thresholds; a
// scoreboard of expected symbols is built from the raw widths driven.
module tb_irig_pulse_classifier;

  localparam int unsigned CNT_W    = 12;
  localparam int unsigned SYNC_ST  = 2;
  localparam int unsigned FILT     = 4;
  localparam int unsigned ZMIN     = 190;
  localparam int unsigned OMIN     = 490;
  localparam int unsigned MMIN     = 790;
  localparam int unsigned MMAX     = 890;
  localparam int unsigned LOSC     = 1200;
  localparam int unsigned LAT      = SYNC_ST + FILT + 1;

  logic             clk;
  logic             rst_n;
  logic             irigb;
  logic             sym_valid;
  logic [1:0]       sym_code;
  logic [CNT_W-1:0] sym_width;
  logic             los;
  logic [7:0]       err_cnt;

  irig_pulse_classifier #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC_ST), .FILT_LEN(FILT), .INVERT(0),
    .ZERO_MIN(ZMIN), .ONE_MIN(OMIN), .MARK_MIN(MMIN), .MARK_MAX(MMAX),
    .LOS_CYCLES(LOSC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irigb(irigb),
    .sym_valid(sym_valid), .sym_code(sym_code), .sym_width(sym_width),
    .los(los), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [1:0]  code;
    int unsigned width;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc_cnt  = 0;
  int unsigned model_err = 0;
  int unsigned last_w   = 0;
  logic        prev_v   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] classify(input int unsigned wd);
    if (wd < ZMIN)       return 2'b11;
    else if (wd < OMIN)  return 2'b00;
    else if (wd < MMIN)  return 2'b01;
    else if (wd <= MMAX) return 2'b10;
    else                 return 2'b11;
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned wd);
    exp_t e;
    e.code  = classify(wd);
    e.width = wd;
    e.due   = cyc_cnt + LAT;
    q.push_back(e);
    last_w = wd;
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo, input bit expect_sym);
    irigb = 1'b1;
    cyc(hi);
    irigb = 1'b0;
    if (expect_sym) push_exp(hi);
    cyc(lo);
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (q.size() != 0 && k < 100) begin
      cyc(1);
      k++;
    end
    check("drain", q.size(), 0);
    check("hold_width", sym_width, last_w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, sym_valid, 0);
    check({tag, "_code"},  sym_code, 0);
    check({tag, "_width"}, sym_width, 0);
    check({tag, "_los"},   los, 0);
    check({tag, "_err"},   err_cnt, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (sym_valid) begin
        check("spacing", prev_v, 0);
        if (q.size() == 0) begin
          check("extra_strobe", sym_valid, 0);
        end else begin
          e = q.pop_front();
          check("latency", cyc_cnt, e.due);
          check("code", sym_code, e.code);
          check("width", sym_width, e.width);
          if (e.code == 2'b11 && model_err < 255) model_err++;
          check("err_cnt", err_cnt, model_err);
        end
      end
      prev_v = sym_valid;
    end
  end

  initial begin
    int unsigned bnd[8];
    int unsigned wd, lo, cls, g1, g2;
    irigb = 1'b0;
    rst_n = 1'b0;
    cyc(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(50);

    // nominal ZERO / ONE / MARK
    pulse(200, 800, 1);
    pulse(500, 500, 1);
    pulse(800, 200, 1);
    drain();

    // random widths in every class, random low times
    for (int i = 0; i < 16; i++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0: wd = $urandom_range(ZMIN, OMIN - 1);
        1: wd = $urandom_range(OMIN, MMIN - 1);
        2: wd = $urandom_range(MMIN, MMAX);
        default: wd = ($urandom_range(0, 1) == 0) ? $urandom_range(20, ZMIN - 1)
                                                  : $urandom_range(MMAX + 1, 950);
      endcase
      lo = $urandom_range(100, 240);
      pulse(wd, lo, 1);
    end
    drain();

    // class boundaries
    bnd = '{ZMIN - 1, ZMIN, OMIN - 1, OMIN, MMIN - 1, MMIN, MMAX, MMAX + 1};
    for (int i = 0; i < 8; i++) pulse(bnd[i], 1000 - bnd[i], 1);
    drain();

    // glitches shorter than the filter must not split or add pulses
    g1 = $urandom_range(100, 400);
    g2 = $urandom_range(100, 400);
    irigb = 1'b1; cyc(g1);
    irigb = 1'b0; cyc(3);
    irigb = 1'b1; cyc(500 - g1 - 3);
    irigb = 1'b0; push_exp(500); cyc(g2);
    irigb = 1'b1; cyc(3);
    irigb = 1'b0; cyc(500 - g2 - 3);
    drain();

    // loss of signal and recovery
    irigb = 1'b1; cyc(200);
    irigb = 1'b0; push_exp(200); cyc(900);
    check("los_early", los, 0);
    cyc(150);
    check("los_set", los, 1);
    cyc(50);
    irigb = 1'b1; cyc(20);
    check("los_clear", los, 0);
    cyc(780);
    irigb = 1'b0; push_exp(800); cyc(200);
    drain();

    // line already high at reset release: that partial pulse is ignored
    irigb = 1'b1; cyc(50);
    rst_n = 1'b0;
    q.delete(); model_err = 0; last_w = 0;
    cyc(5);
    check_reset_outputs("reset2");
    rst_n = 1'b1;
    cyc(300);
    irigb = 1'b0; cyc(300);
    pulse(200, 300, 1);
    drain();

    // asynchronous reset mid-pulse with non-zero outputs beforehand
    pulse(50, 100, 1);
    drain();
    irigb = 1'b1; cyc(100);
    #2 rst_n = 1'b0;
    q.delete(); model_err = 0; last_w = 0;
    #1;
    check_reset_outputs("async_rst");
    cyc(3);
    rst_n = 1'b1;
    cyc(100);
    irigb = 1'b0; cyc(100);
    drain();

    // err_cnt saturation
    for (int i = 0; i < 300; i++) pulse($urandom_range(10, 100), 20, 1);
    drain();
    check("err_sat", err_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
